// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and position width for the VGA sync path
// and the graphics blocks that consume pix_x/pix_y.
package vga_pkg;

    localparam int unsigned PIX_W  = 10;

    localparam int unsigned H_DISP = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned V_DISP = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;

    localparam int unsigned H_TOT  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT  = V_DISP + V_FP + V_SYNC + V_BP;

    // True when lo <= pos < hi; used for the active-low sync windows.
    function automatic logic in_window(input logic [PIX_W-1:0] pos,
                                       input logic [PIX_W-1:0] lo,
                                       input logic [PIX_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Pixel clock-enable divider: tick is a registered one-clock pulse every DIV clocks,
// aligned with div_cnt == DIV-1.
module pix_tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          tick_q, tick_d;

    // Next divider count; tick is decoded from the next count so it lines up with div_cnt.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (div_cnt_q == LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
        tick_d = (div_cnt_d == LAST);
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA position counters and sync decode. Optional 16-bit frame counter port is
// enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned DIV    = 4,
    parameter int unsigned H_DISP = vga_pkg::H_DISP,
    parameter int unsigned H_FP   = vga_pkg::H_FP,
    parameter int unsigned H_SYNC = vga_pkg::H_SYNC,
    parameter int unsigned H_BP   = vga_pkg::H_BP,
    parameter int unsigned V_DISP = vga_pkg::V_DISP,
    parameter int unsigned V_FP   = vga_pkg::V_FP,
    parameter int unsigned V_SYNC = vga_pkg::V_SYNC,
    parameter int unsigned V_BP   = vga_pkg::V_BP
) (
    input  logic             clk,
    input  logic             reset,
    output logic             p_tick,
    output logic [PIX_W-1:0] pix_x,
    output logic [PIX_W-1:0] pix_y,
    output logic             video,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_tick
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);
    localparam int unsigned HT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [PIX_W-1:0] H_LAST = PIX_W'(HT - 1);
    localparam logic [PIX_W-1:0] V_LAST = PIX_W'(VT - 1);
    localparam logic [PIX_W-1:0] H_VIS  = PIX_W'(H_DISP);
    localparam logic [PIX_W-1:0] V_VIS  = PIX_W'(V_DISP);
    localparam logic [PIX_W-1:0] HS_LO  = PIX_W'(H_DISP + H_FP);
    localparam logic [PIX_W-1:0] HS_HI  = PIX_W'(H_DISP + H_FP + H_SYNC);
    localparam logic [PIX_W-1:0] VS_LO  = PIX_W'(V_DISP + V_FP);
    localparam logic [PIX_W-1:0] VS_HI  = PIX_W'(V_DISP + V_FP + V_SYNC);

    logic             tick_s;
    logic [PIX_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic             video_q, video_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic             frame_tick_q, frame_tick_d;

    pix_tick_div #(.DIV(DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // Counter advance plus decode from next-state values, so outputs never lag pix_x/pix_y.
    always_comb begin
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        frame_tick_d = 1'b0;
        if (tick_s) begin
            if (pix_x_q == H_LAST) begin
                pix_x_d = '0;
                if (pix_y_q == V_LAST) begin
                    pix_y_d      = '0;
                    frame_tick_d = 1'b1;
                end else begin
                    pix_y_d = pix_y_q + 1'b1;
                end
            end else begin
                pix_x_d = pix_x_q + 1'b1;
            end
        end else begin
            pix_x_d = pix_x_q;
        end
        video_d = (pix_x_d < H_VIS) && (pix_y_d < V_VIS);
        hsync_d = ~in_window(pix_x_d, HS_LO, HS_HI);
        vsync_d = ~in_window(pix_y_d, VS_LO, VS_HI);
    end

    // Position and decoded-output registers; reset wins over the pixel enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            video_q      <= 1'b1;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            video_q      <= video_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frame count steps on the same edge that raises frame_tick and wraps naturally.
    always_comb begin
        if (frame_tick_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign p_tick     = tick_s;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign video      = video_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size 640x480 instance (DIV=4) and a reduced-timing
// DIV=2 instance whose short frame allows complete-frame checks.
module tb_vga_sync_gen;

    localparam int A_DIV = 4, A_HD = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VD = 480, A_VF = 10, A_VS = 2, A_VB = 33;
    localparam int B_DIV = 2, B_HD = 20, B_HF = 2, B_HS = 4, B_HB = 2;
    localparam int B_VD = 10, B_VF = 2, B_VS = 2, B_VB = 3;
    localparam int B_FRAME_CLK = (B_HD + B_HF + B_HS + B_HB) * (B_VD + B_VF + B_VS + B_VB) * B_DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       a_tick, a_video, a_hs, a_vs, a_ft;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_video, b_hs, b_vs, b_ft;
    logic [9:0] b_x, b_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] a_fc, b_fc;
`endif

    vga_sync_gen #(.DIV(A_DIV), .H_DISP(A_HD), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
                   .V_DISP(A_VD), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB)) u_a (
        .clk(clk), .reset(reset), .p_tick(a_tick), .pix_x(a_x), .pix_y(a_y),
        .video(a_video), .hsync(a_hs), .vsync(a_vs), .frame_tick(a_ft)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    vga_sync_gen #(.DIV(B_DIV), .H_DISP(B_HD), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
                   .V_DISP(B_VD), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)) u_b (
        .clk(clk), .reset(reset), .p_tick(b_tick), .pix_x(b_x), .pix_y(b_y),
        .video(b_video), .hsync(b_hs), .vsync(b_vs), .frame_tick(b_ft)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .frame_cnt(b_fc)
`endif
    );

    typedef struct {
        logic        tick;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        video;
        logic        hs;
        logic        vs;
        logic        ft;
        logic [15:0] fc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   c        = 0;   // clocks since the last edge that sampled reset high

    // Closed-form reference: position is the number of completed pixel periods.
    function automatic exp_t model(input int cyc, input int div,
                                   input int hd, input int hf, input int hs, input int hb,
                                   input int vd, input int vf, input int vs, input int vb);
        exp_t e;
        int ht, vt, n, f, x, y;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        n  = cyc / div;
        f  = ht * vt;
        x  = n % ht;
        y  = (n / ht) % vt;
        e.tick  = ((cyc % div) == div - 1);
        e.x     = 10'(x);
        e.y     = 10'(y);
        e.video = (x < hd) && (y < vd);
        e.hs    = !((x >= hd + hf) && (x < hd + hf + hs));
        e.vs    = !((y >= vd + vf) && (y < vd + vf + vs));
        e.ft    = (n > 0) && ((n % f) == 0) && ((cyc % div) == 0);
        e.fc    = 16'((n / f) % 65536);
        return e;
    endfunction

    // One clock: drive reset, queue expectations for the post-edge state, compare at negedge.
    task automatic sb_cycle(input logic rst);
        exp_t ea, eb;
        logic [25:0] got, want;
        reset = rst;
        @(posedge clk);
        if (rst) c = 0;
        else     c = c + 1;
        q_a.push_back(model(c, A_DIV, A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB));
        q_b.push_back(model(c, B_DIV, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB));
        @(negedge clk);
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        got  = {a_tick, a_x, a_y, a_video, a_hs, a_vs, a_ft};
        want = {ea.tick, ea.x, ea.y, ea.video, ea.hs, ea.vs, ea.ft};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL sb_a c=%0d got tick/x/y/vid/hs/vs/ft=%b/%0d/%0d/%b/%b/%b/%b want %b/%0d/%0d/%b/%b/%b/%b",
                     c, a_tick, a_x, a_y, a_video, a_hs, a_vs, a_ft,
                     ea.tick, ea.x, ea.y, ea.video, ea.hs, ea.vs, ea.ft);
        end
        got  = {b_tick, b_x, b_y, b_video, b_hs, b_vs, b_ft};
        want = {eb.tick, eb.x, eb.y, eb.video, eb.hs, eb.vs, eb.ft};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL sb_b c=%0d got tick/x/y/vid/hs/vs/ft=%b/%0d/%0d/%b/%b/%b/%b want %b/%0d/%0d/%b/%b/%b/%b",
                     c, b_tick, b_x, b_y, b_video, b_hs, b_vs, b_ft,
                     eb.tick, eb.x, eb.y, eb.video, eb.hs, eb.vs, eb.ft);
        end
`ifdef VGA_SYNC_FRAME_CNT_EN
        n_checks++;
        if (a_fc !== ea.fc || b_fc !== eb.fc) begin
            n_fail++;
            $display("FAIL sb_frame_cnt c=%0d got a=%0d b=%0d want a=%0d b=%0d", c, a_fc, b_fc, ea.fc, eb.fc);
        end
`endif
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) sb_cycle(1'b1);
        n_checks++;
        if ({a_tick, a_x, a_y, a_video, a_hs, a_vs, a_ft} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values got tick=%b x=%0d y=%0d vid=%b hs=%b vs=%b ft=%b want 0 0 0 1 1 1 0",
                     a_tick, a_x, a_y, a_video, a_hs, a_vs, a_ft);
        end
        n_checks++;
        if (u_a.u_div.div_cnt_q !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_div_cnt got %0d want 0", u_a.u_div.div_cnt_q);
        end
    endtask

    task automatic test_tick();
        int first_a, first_b, cnt_a;
        first_a = -1; first_b = -1; cnt_a = 0;
        for (int i = 0; i < 16; i++) begin
            sb_cycle(1'b0);
            if (a_tick) begin
                cnt_a++;
                if (first_a < 0) first_a = c;
            end
            if (b_tick && first_b < 0) first_b = c;
        end
        n_checks++;
        if (first_a != 3 || cnt_a != 4) begin
            n_fail++;
            $display("FAIL tick_div4 got first=%0d count=%0d want first=3 count=4", first_a, cnt_a);
        end
        n_checks++;
        if (first_b != 1) begin
            n_fail++;
            $display("FAIL tick_div2 got first=%0d want 1", first_b);
        end
    endtask

    task automatic test_line();
        int hs_fall_x, hs_rise_x, vid_fall_x, wrap_y;
        logic prev_hs, prev_vid;
        logic [9:0] prev_x;
        hs_fall_x = -1; hs_rise_x = -1; vid_fall_x = -1; wrap_y = -1;
        prev_hs = a_hs; prev_vid = a_video; prev_x = a_x;
        while (c < 3210) begin
            sb_cycle(1'b0);
            if (prev_hs && !a_hs && hs_fall_x < 0) hs_fall_x = int'(a_x);
            if (!prev_hs && a_hs && hs_rise_x < 0) hs_rise_x = int'(a_x);
            if (prev_vid && !a_video && vid_fall_x < 0) vid_fall_x = int'(a_x);
            if (prev_x == 10'd799 && a_x == 10'd0 && wrap_y < 0) wrap_y = int'(a_y);
            prev_hs = a_hs; prev_vid = a_video; prev_x = a_x;
        end
        n_checks++;
        if (hs_fall_x != 656 || hs_rise_x != 752) begin
            n_fail++;
            $display("FAIL hsync_window got fall_x=%0d rise_x=%0d want 656 752", hs_fall_x, hs_rise_x);
        end
        n_checks++;
        if (vid_fall_x != 640) begin
            n_fail++;
            $display("FAIL video_drop got x=%0d want 640", vid_fall_x);
        end
        n_checks++;
        if (wrap_y != 1) begin
            n_fail++;
            $display("FAIL line_wrap got pix_y=%0d want 1", wrap_y);
        end
    endtask

    task automatic test_mid_reset();
        while (c < 4402) sb_cycle(1'b0);
        n_checks++;
        if (a_x !== 10'd300 || a_y !== 10'd1 || u_a.u_div.div_cnt_q !== 2'd2) begin
            n_fail++;
            $display("FAIL mid_pos got x=%0d y=%0d div=%0d want 300 1 2", a_x, a_y, u_a.u_div.div_cnt_q);
        end
        sb_cycle(1'b1);
        n_checks++;
        if (a_x !== 10'd0 || a_y !== 10'd0 || a_tick !== 1'b0 || u_a.u_div.div_cnt_q !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset got x=%0d y=%0d tick=%b div=%0d want 0 0 0 0",
                     a_x, a_y, a_tick, u_a.u_div.div_cnt_q);
        end
        for (int i = 0; i < 4; i++) sb_cycle(1'b0);
    endtask

    task automatic test_frame();
        int ft_cnt, first_ft, bad_ft, bad_vs, mark_cnt;
        logic [9:0] prev_y;
        ft_cnt = 0; first_ft = -1; bad_ft = 0; bad_vs = 0; mark_cnt = 0;
        sb_cycle(1'b1);
        prev_y = b_y;
        while (c < 3 * B_FRAME_CLK + 3) begin
            sb_cycle(1'b0);
            if (b_ft) begin
                ft_cnt++;
                if (first_ft < 0) first_ft = c;
                if (b_x !== 10'd0 || b_y !== 10'd0) bad_ft++;
            end
            if (!b_vs && (b_y < 10'd12 || b_y > 10'd13)) bad_vs++;
            if (b_y == 10'd14 && prev_y == 10'd13) mark_cnt++;
            prev_y = b_y;
        end
        n_checks++;
        if (ft_cnt != 3 || first_ft != B_FRAME_CLK || bad_ft != 0) begin
            n_fail++;
            $display("FAIL frame_tick got count=%0d first=%0d off_origin=%0d want 3 %0d 0",
                     ft_cnt, first_ft, bad_ft, B_FRAME_CLK);
        end
        n_checks++;
        if (bad_vs != 0) begin
            n_fail++;
            $display("FAIL vsync_window got %0d low cycles outside lines 12..13 want 0", bad_vs);
        end
        n_checks++;
        if (mark_cnt != 3) begin
            n_fail++;
            $display("FAIL line_mark got %0d entries to line 14 want 3", mark_cnt);
        end
`ifdef VGA_SYNC_FRAME_CNT_EN
        n_checks++;
        if (b_fc !== 16'd3) begin
            n_fail++;
            $display("FAIL frame_cnt3 got %0d want 3", b_fc);
        end
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_tick();
        test_line();
        test_mid_reset();
        test_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Pixel-timing source for the 640x480@60 Hz display path. Divides the 100 MHz system clock into a pixel clock-enable, runs horizontal/vertical position counters, and drives `hsync`, `vsync`, `video`, `pix_x`, `pix_y` and `p_tick` to the graphics blocks (paddle/ball renderer, score overlay) and to the VGA connector. Graphics logic uses `pix_y == 500 && pix_x == 0` as its once-per-frame update point, so the full vertical range 0..524 must be visible on `pix_y`.

## Interface
- `DIV`, 4: system clocks per pixel; legal range 2..16.
- `H_DISP`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_DISP`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-high. Clock is `clk`.
- `p_tick` out 1: pixel enable, high for one `clk` every `DIV` clocks.
- `pix_x` out 10: horizontal count, 0..H_TOT-1.
- `pix_y` out 10: vertical count, 0..V_TOT-1.
- `video` out 1: high when `pix_x < H_DISP` and `pix_y < V_DISP`.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `frame_tick` out 1: one-`clk` pulse when the counters wrap to (0,0).
- `frame_cnt` out 16: frames since reset. Present only with `VGA_SYNC_FRAME_CNT_EN`.

## Operation
- H_TOT = H_DISP+H_FP+H_SYNC+H_BP (800). V_TOT = V_DISP+V_FP+V_SYNC+V_BP (525). Both must be ≤1024; widths are fixed at 10 bits.
- Divider `div_cnt` counts 0..DIV-1 and wraps. `p_tick` = (`div_cnt` == DIV-1), registered so it is glitch-free.
- On a `clk` edge where `p_tick` is high:
  - `pix_x` increments.
  - When `pix_x` == H_TOT-1, `pix_x` goes to 0 and `pix_y` increments.
  - When `pix_y` == V_TOT-1 at the same time, `pix_y` also goes to 0.
- `hsync` is low when `pix_x` is in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1], i.e. 656..751.
- `vsync` is low when `pix_y` is in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1], i.e. 490..491.
- `hsync`, `vsync` and `video` are registers computed from next-state counter values. They are therefore always consistent with the current `pix_x`/`pix_y`, with zero offset.
- `frame_tick` is registered and is high for exactly one `clk`, in the cycle where (`pix_x`,`pix_y`) first reads (0,0) after the wrap from (799,524).
- Reset has priority over `p_tick`. A reset mid-frame returns every register to its reset value on that same edge, with no partial line.

## Timing
- Reset values:
  - `div_cnt`=0, `p_tick`=0.
  - `pix_x`=0, `pix_y`=0.
  - `video`=1, consistent with (0,0).
  - `hsync`=1, `vsync`=1.
  - `frame_tick`=0, `frame_cnt`=0.
- First `p_tick` is high in the DIV-th `clk` cycle after reset deasserts (cycle index DIV-1). The counters advance on that edge.
- Counters are stable for DIV clocks. `p_tick` period is exactly DIV clocks with duty 1/DIV.
- Line = H_TOT*DIV clocks (3200). Frame = V_TOT*H_TOT*DIV clocks (1,680,000).
- There is no latency between counter state and the decoded outputs; all of them change on the same edge.

## Configuration
- `VGA_SYNC_FRAME_CNT_EN` defined:
  - `frame_cnt` port and register exist.
  - `frame_cnt` increments on the edge that asserts `frame_tick`.
  - It wraps from 65535 to 0 and resets to 0.
- Undefined: port and register are absent. All other behaviour is identical.

## Structure
- Shared package `vga_pkg`:
  - H/V timing constants (640/16/96/48, 480/10/2/33).
  - Derived H_TOT/V_TOT.
  - The `pix_x`/`pix_y` width (10), so graphics blocks share the same constants.
- One sub-module, `pix_tick_div`:
  - Parameter DIV.
  - Ports `clk`, `reset`, `tick`.
  - Contains `div_cnt` and the registered tick.
- The counters and sync decode stay in `vga_sync_gen`.

## Test plan
- Reset held 5 clocks, then released:
  - All outputs at their reset values during reset.
  - `p_tick` first high at clock 3 after release, then every 4 clocks.
- Run one line:
  - `hsync` goes low on the edge `pix_x` becomes 656 and high on the edge it becomes 752.
  - `video` drops at `pix_x`=640.
  - `pix_x` wraps 799→0 with `pix_y` +1.
- Run a full frame:
  - `vsync` is low only for `pix_y` 490..491.
  - `pix_y`=500 with `pix_x`=0 occurs exactly once.
  - `frame_tick` fires once after 1,680,000 clocks, coincident with (0,0).
- Assert reset at `pix_x`=300, `pix_y`=200, mid-`div_cnt`:
  - Next edge gives `pix_x`=0, `pix_y`=0, `p_tick`=0.
  - `div_cnt` restarts at 0.
- With `VGA_SYNC_FRAME_CNT_EN`, run 3 frames: `frame_cnt` reads 3. Force `frame_cnt` to 65535, then one frame: it reads 0.
- `DIV`=2 build: `p_tick` period is 2 clocks and the frame is 840,000 clocks.
